// File: rtl/id_scoreboard_ctrl_pkg.sv
// Shared types and defaults for the decode-stage issue scoreboard.
// State encoding is visible on the top-level state port.
package id_scoreboard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DEBUG = 2'd2
    } state_e;

    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 2;
    localparam int REG_ZERO   = 0;

endpackage

// File: rtl/id_scoreboard_ctrl_reg_pending_counter.sv
// Saturating up/down count of in-flight writes to one register.
// clr wins over any simultaneous inc/dec.
module reg_pending_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count
);

    logic up;
    logic down;

    assign up   = inc & (count != '1);
    assign down = dec & (count != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (up & ~down) begin
            count <= count + 1'b1;
        end else if (down & ~up) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/id_scoreboard_ctrl.sv
// Decode issue scheduler: RAW/saturation stall and write-port
// arbitration between pipeline writeback and the debug writer.
module id_scoreboard_ctrl
    import id_scoreboard_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rs,
    input  logic [ADDR_W-1:0] issue_rt,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              uses_rs,
    input  logic              uses_rt,
    input  logic              writes_rd,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              flush,
    input  logic              dbg_req,
    output logic              stall,
    output logic              issue_fire,
    output logic              dbg_grant,
    output logic              wr_sel,
    output logic              pending_any,
    output logic [1:0]        state
);

    localparam logic [CNT_W-1:0]  MAX  = '1;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] nz;
    state_e              state_q;
    state_e              state_n;
    logic                grant_q;
    logic                rs_busy;
    logic                rt_busy;
    logic                rd_full;
    logic                haz;

    assign cnt[0] = '0;
    assign nz[0]  = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        logic inc;
        logic dec;

        assign inc = issue_fire & writes_rd
                   & (issue_rd == ADDR_W'(r));
        assign dec = wb_valid & (wb_rd == ADDR_W'(r));

        reg_pending_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (flush),
            .inc   (inc),
            .dec   (dec),
            .count (cnt[r])
        );

        assign nz[r] = |cnt[r];
    end

    // Registered counters only: a writeback this cycle does not unstall.
    assign rs_busy = uses_rs & (issue_rs != ZERO)
                   & (cnt[issue_rs] != '0);
    assign rt_busy = uses_rt & (issue_rt != ZERO)
                   & (cnt[issue_rt] != '0);
    assign rd_full = writes_rd & (issue_rd != ZERO)
                   & (cnt[issue_rd] == MAX);
    assign haz     = rs_busy | rt_busy | rd_full;

    assign stall       = issue_valid & ((state_q != ST_RUN) | haz);
    assign issue_fire  = issue_valid & ~stall & ~flush;
    assign pending_any = |nz;
    assign state       = state_q;
    assign dbg_grant   = grant_q;
    assign wr_sel      = grant_q;

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (dbg_req) state_n = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!dbg_req)         state_n = ST_RUN;
                else if (!pending_any) state_n = ST_DEBUG;
            end
            ST_DEBUG: begin
                if (!dbg_req) state_n = ST_RUN;
            end
            default: state_n = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_n;
            grant_q <= (state_n == ST_DEBUG);
        end
    end

endmodule
